// File: rtl/maxpool1_relu.sv
// maxpool1_relu: 2x2 stride-2 max pooling over three conv1 channels, with an
// optional ReLU after the max. The input is a raster stream of CONV_WIDTH x
// CONV_HEIGHT pixels. The output is a raster stream of pooled pixels that is
// one quarter the size.
// The ReLU clamp is enabled by defining MAXPOOL1_RELU_EN.
// The default build passes the signed max through unmodified.
module maxpool1_relu #(
  parameter int CONV_WIDTH  = 24,
  parameter int CONV_HEIGHT = 24,
  parameter int DATA_BITS   = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  input  logic signed [DATA_BITS-1:0] conv_out_1,
  input  logic signed [DATA_BITS-1:0] conv_out_2,
  input  logic signed [DATA_BITS-1:0] conv_out_3,
  output logic signed [DATA_BITS-1:0] max_value_1,
  output logic signed [DATA_BITS-1:0] max_value_2,
  output logic signed [DATA_BITS-1:0] max_value_3,
  output logic                        valid_out_relu,
  output logic                        frame_done
);

  localparam int HALF_W = CONV_WIDTH / 2;
  localparam int CW     = (CONV_WIDTH > 1) ? $clog2(CONV_WIDTH) : 1;
  localparam int RW     = (CONV_HEIGHT > 1) ? $clog2(CONV_HEIGHT) : 1;
  localparam int LW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(CONV_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(CONV_HEIGHT - 1);

  function automatic logic signed [DATA_BITS-1:0] smax(
    input logic signed [DATA_BITS-1:0] a,
    input logic signed [DATA_BITS-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // Optional clamp of negative pooled results to zero.
  function automatic logic signed [DATA_BITS-1:0] relu(
    input logic signed [DATA_BITS-1:0] x
  );
`ifdef MAXPOOL1_RELU_EN
    return x[DATA_BITS-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  // ---- stage p0: raster position, horizontal pair, vertical pair ----
  logic [CW-1:0]               col_p0;
  logic [RW-1:0]               row_p0;
  logic signed [DATA_BITS-1:0] pix_p0   [3];
  logic signed [DATA_BITS-1:0] hold_p0  [3];
  logic signed [DATA_BITS-1:0] lbuf_p0  [3][HALF_W];
  logic signed [DATA_BITS-1:0] pair_max [3];
  logic signed [DATA_BITS-1:0] win_max  [3];
  logic [LW-1:0]               lb_idx;
  logic                        col_odd, row_odd, win_end, frame_end;

  assign pix_p0[0] = conv_out_1;
  assign pix_p0[1] = conv_out_2;
  assign pix_p0[2] = conv_out_3;

  assign lb_idx    = LW'(col_p0 >> 1);
  assign col_odd   = col_p0[0];
  assign row_odd   = row_p0[0];
  assign win_end   = valid_in && col_odd && row_odd;
  assign frame_end = win_end && (col_p0 == COL_LAST) && (row_p0 == ROW_LAST);

  // Raster position of the pixel currently on the input; moves only on beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (valid_in) begin
      if (col_p0 == COL_LAST) begin
        col_p0 <= '0;
        row_p0 <= (row_p0 == ROW_LAST) ? '0 : row_p0 + 1'b1;
      end else begin
        col_p0 <= col_p0 + 1'b1;
      end
    end
  end

  // Even-column pixel waits here for its odd-column partner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < 3; ch++) hold_p0[ch] <= '0;
    end else if (valid_in && !col_odd) begin
      for (int ch = 0; ch < 3; ch++) hold_p0[ch] <= pix_p0[ch];
    end
  end

  // Horizontal pair max, then vertical max against the row above.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      pair_max[ch] = smax(hold_p0[ch], pix_p0[ch]);
      win_max[ch]  = smax(lbuf_p0[ch][lb_idx], pair_max[ch]);
    end
  end

  // Even rows park their pair max for the odd row below. No reset is needed
  // because every entry is rewritten before the odd row reads it.
  always_ff @(posedge clk) begin
    if (valid_in && col_odd && !row_odd) begin
      for (int ch = 0; ch < 3; ch++) lbuf_p0[ch][lb_idx] <= pair_max[ch];
    end
  end

  // ---- stage p1: registered pooled output ----
  logic signed [DATA_BITS-1:0] max_p1 [3];
  logic                        vld_p1;
  logic                        done_p1;

  // Capture the window result on its bottom-right beat. Otherwise hold the value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < 3; ch++) max_p1[ch] <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      vld_p1  <= win_end;
      done_p1 <= frame_end;
      if (win_end) begin
        for (int ch = 0; ch < 3; ch++) max_p1[ch] <= relu(win_max[ch]);
      end
    end
  end

  assign max_value_1    = max_p1[0];
  assign max_value_2    = max_p1[1];
  assign max_value_3    = max_p1[2];
  assign valid_out_relu = vld_p1;
  assign frame_done     = done_p1;

endmodule

// File: tb/tb_maxpool1_relu.sv
// Testbench for maxpool1_relu with default 24x24 geometry and 12-bit samples.
// Checks run against a whole-frame reference. Build with MAXPOOL1_RELU_EN
// defined to check the ReLU variant.
module tb_maxpool1_relu;

  localparam int W  = 24;
  localparam int H  = 24;
  localparam int DB = 12;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 valid_in;
  logic signed [DB-1:0] conv_out_1, conv_out_2, conv_out_3;
  logic signed [DB-1:0] max_value_1, max_value_2, max_value_3;
  logic                 valid_out_relu;
  logic                 frame_done;

  maxpool1_relu #(.CONV_WIDTH(W), .CONV_HEIGHT(H), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .conv_out_1(conv_out_1), .conv_out_2(conv_out_2), .conv_out_3(conv_out_3),
    .max_value_1(max_value_1), .max_value_2(max_value_2), .max_value_3(max_value_3),
    .valid_out_relu(valid_out_relu), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: every pixel of the frame is kept. When a 2x2 window
  // completes, the expected output is the max of its four stored pixels.
  int fp [3][H][W];
  int mr = 0, mc = 0;
  int e_v [3] = '{0, 0, 0};
  int outq1[$], outq2[$], outq3[$];
  int doneq[$];
  int nstrobe = 0;

  function automatic int ref_relu(input int x);
`ifdef MAXPOOL1_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  initial begin
    forever begin
      bit e_stb, e_done;
      int px [3];
      @(posedge clk);
      e_stb  = 1'b0;
      e_done = 1'b0;
      if (rst) begin
        mr = 0; mc = 0;
        e_v = '{0, 0, 0};
      end else if (valid_in) begin
        px[0] = int'(conv_out_1);
        px[1] = int'(conv_out_2);
        px[2] = int'(conv_out_3);
        for (int ch = 0; ch < 3; ch++) fp[ch][mr][mc] = px[ch];
        if ((mr % 2 == 1) && (mc % 2 == 1)) begin
          for (int ch = 0; ch < 3; ch++) begin
            int m;
            m = fp[ch][mr-1][mc-1];
            if (fp[ch][mr-1][mc] > m) m = fp[ch][mr-1][mc];
            if (fp[ch][mr][mc-1] > m) m = fp[ch][mr][mc-1];
            if (fp[ch][mr][mc]   > m) m = fp[ch][mr][mc];
            e_v[ch] = ref_relu(m);
          end
          e_stb  = 1'b1;
          e_done = (mr == H - 1) && (mc == W - 1);
        end
        mc++;
        if (mc == W) begin
          mc = 0;
          mr = (mr == H - 1) ? 0 : mr + 1;
        end
      end
      #1;
      check_val("valid_out", int'(valid_out_relu), int'(e_stb));
      check_val("frame_done", int'(frame_done), int'(e_done));
      check_val("max_value_1", int'(max_value_1), e_v[0]);
      check_val("max_value_2", int'(max_value_2), e_v[1]);
      check_val("max_value_3", int'(max_value_3), e_v[2]);
      if (valid_out_relu) begin
        outq1.push_back(int'(max_value_1));
        outq2.push_back(int'(max_value_2));
        outq3.push_back(int'(max_value_3));
        if (frame_done) doneq.push_back(nstrobe);
        nstrobe++;
      end
    end
  end

  task automatic clear_rec();
    outq1.delete(); outq2.delete(); outq3.delete(); doneq.delete();
    nstrobe = 0;
  endtask

  // Pixel patterns: 0 random, 1 ramp on ch1, 2 negative first window,
  // 3 ch2 alternating 0x7FF / 0x800.
  function automatic logic [DB-1:0] gen(input int mode, input int ch, input int r, input int c);
    logic [DB-1:0] v;
    int wnd [4] = '{-5, -3, -8, -2};
    v = DB'($urandom);
    case (mode)
      1: if (ch == 0) v = DB'(r * W + c);
      2: if (r < 2 && c < 2) v = DB'(wnd[r * 2 + c]);
      3: if (ch == 1) v = (c % 2 == 0) ? 12'h7FF : 12'h800;
      default: ;
    endcase
    return v;
  endfunction

  task automatic send_frame(input int mode, input bit gaps, input int nbeats);
    for (int idx = 0; idx < nbeats; idx++) begin
      int r, c;
      r = (idx / W) % H;
      c = idx % W;
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          @(negedge clk);
          valid_in   = 1'b0;
          conv_out_1 = DB'($urandom);
          conv_out_2 = DB'($urandom);
          conv_out_3 = DB'($urandom);
        end
      end
      @(negedge clk);
      valid_in   = 1'b1;
      conv_out_1 = gen(mode, 0, r, c);
      conv_out_2 = gen(mode, 1, r, c);
      conv_out_3 = gen(mode, 2, r, c);
    end
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int bad_alt;
`ifdef MAXPOOL1_RELU_EN
    int neg_exp = 0;
`else
    int neg_exp = -2;
`endif
    rst = 1'b1; valid_in = 1'b0;
    conv_out_1 = '0; conv_out_2 = '0; conv_out_3 = '0;
    idle(3);
    check_val("rst_vld", int'(valid_out_relu), 0);
    check_val("rst_max1", int'(max_value_1), 0);
    check_val("rst_done", int'(frame_done), 0);
    rst = 1'b0;
    idle(2);

    // Ramp frame, back-to-back beats.
    clear_rec();
    send_frame(1, 1'b0, W * H);
    idle(3);
    check_val("ramp_count", nstrobe, 144);
    check_val("ramp_first", (outq1.size() > 0) ? outq1[0] : -9999, 25);
    check_val("ramp_last", (outq1.size() > 0) ? outq1[outq1.size()-1] : -9999, 575);
    check_val("ramp_ndone", doneq.size(), 1);
    check_val("ramp_done_at", (doneq.size() > 0) ? doneq[0] : -1, 143);

    // Negative first window.
    clear_rec();
    send_frame(2, 1'b0, W * H);
    idle(3);
    check_val("neg_ch1", (outq1.size() > 0) ? outq1[0] : -9999, neg_exp);
    check_val("neg_ch2", (outq2.size() > 0) ? outq2[0] : -9999, neg_exp);
    check_val("neg_ch3", (outq3.size() > 0) ? outq3[0] : -9999, neg_exp);

    // Ramp frame with random input gaps.
    clear_rec();
    send_frame(1, 1'b1, W * H);
    idle(3);
    check_val("gap_count", nstrobe, 144);
    check_val("gap_first", (outq1.size() > 0) ? outq1[0] : -9999, 25);
    check_val("gap_last", (outq1.size() > 0) ? outq1[outq1.size()-1] : -9999, 575);

    // Partial frame, reset, then a clean frame.
    send_frame(0, 1'b0, 300);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_vld", int'(valid_out_relu), 0);
    check_val("midrst_max2", int'(max_value_2), 0);
    rst = 1'b0;
    clear_rec();
    send_frame(0, 1'b0, W * H);
    idle(3);
    check_val("postrst_count", nstrobe, 144);
    check_val("postrst_ndone", doneq.size(), 1);

    // Two frames back-to-back with ch2 alternating extremes.
    clear_rec();
    send_frame(3, 1'b0, 2 * W * H);
    idle(3);
    bad_alt = 0;
    foreach (outq2[i]) if (outq2[i] != 2047) bad_alt++;
    check_val("alt_count", nstrobe, 288);
    check_val("alt_all_7ff", bad_alt, 0);
    check_val("alt_ndone", doneq.size(), 2);
    check_val("alt_done_gap", (doneq.size() == 2) ? doneq[1] - doneq[0] : -1, 144);

    // Random data with gaps, two frames.
    clear_rec();
    send_frame(0, 1'b1, 2 * W * H);
    idle(3);
    check_val("rand_count", nstrobe, 288);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
